support_seq: RTL and testbench
==============================

# support_seq

Parametrised single-clock reset/boot sequencer for the board support layer. It debounces NUM_BTN front-panel buttons and sequences clock-manager reset, LPDDR reset and calibration wait, CPU reset and the boot strobe. It drives real halt and interrupt outputs and adds warm reset, full reset and an interrupt acknowledge handshake. It sits between the board pins and the CPU/memory top level.

## Interface
- TICK_DIV, 4096: sysclk cycles per debounce tick (≥2).
- DEB_TICKS, 10: consecutive equal tick samples needed to change a debounced level (≥2).
- NUM_BTN, 4: button count (≥4). Bit 0 is reset, bit 1 is boot (warm reset), bit 2 is halt toggle, bit 3 is interrupt. Higher bits only raise press events.
- DCM_CYCLES, 64: cycles dcm_reset is held.
- RST_CYCLES, 16: cycles lpddr_reset is held; also cycles cpu_reset is held in S_CPURST.
- BOOT_CYCLES, 4: cycles boot is held.
- CALIB_TIMEOUT, 1048576: calibration wait limit in cycles.
- sysclk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- button  in  NUM_BTN  raw active-high buttons, asynchronous.
- lpddr_calib_done  in  1  memory calibration complete.
- int_ack  in  1  CPU acknowledges interrupt.
- dcm_reset  out  1  clock manager reset.
- lpddr_reset  out  1  memory controller reset.
- cpu_reset  out  1  CPU reset.
- boot  out  1  boot strobe.
- halt  out  1  CPU halt request, level.
- interrupt  out  1  interrupt request, held until acknowledged.
- btn_press  out  NUM_BTN  one-cycle debounced press events.
- calib_err  out  1  calibration timed out (sticky).

## Operation
- Input path: each button passes a 2-flop synchroniser, then a shift history clocked on the prescaler tick. The debounced level flips only when all DEB_TICKS samples agree. btn_press[i] pulses for one cycle on a 0→1 debounced transition.
- States: S_INIT → S_MEMRST → S_CALIB → S_CPURST → S_BOOT → S_RUN. One phase counter is reloaded on every state entry.
  - S_INIT: dcm_reset=1 and cpu_reset=1 for DCM_CYCLES cycles.
  - S_MEMRST: lpddr_reset=1 and cpu_reset=1 for RST_CYCLES cycles.
  - S_CALIB: cpu_reset=1. Exit on lpddr_calib_done=1.
  - S_CPURST: cpu_reset=1 for RST_CYCLES cycles.
  - S_BOOT: cpu_reset=0 and boot=1 for BOOT_CYCLES cycles.
  - S_RUN: all reset outputs and boot are 0.
- Press handling:
  - btn_press[0] in any state except S_INIT/S_MEMRST → S_MEMRST (full reset).
  - btn_press[1] in S_RUN → S_CPURST (warm reset; memory untouched).
  - Same cycle: reset wins over boot.
- halt: toggles on btn_press[2] in S_RUN. Cleared on entry to S_MEMRST or S_CPURST.
- interrupt:
  - Set by btn_press[3] in S_RUN.
  - Cleared in the cycle after int_ack=1 is sampled.
  - Presses while pending are dropped.
  - If int_ack and a press coincide while pending, the result is clear (0).
  - Cleared on entry to S_MEMRST or S_CPURST.
- Press events of other buttons have no effect on state.
- Reset values (reset_n low): state S_INIT with counter reloaded. dcm_reset=1, cpu_reset=1. All other outputs 0, debounce histories 0, prescaler 0.

## Timing
- All outputs are registered.
- Reset phases:
  - After reset_n rises, dcm_reset stays 1 for exactly DCM_CYCLES rising edges.
  - lpddr_reset is 1 for exactly RST_CYCLES cycles, starting the cycle dcm_reset falls.
- Calibration: if lpddr_calib_done is already 1 on entry to S_CALIB, the block leaves S_CALIB after 1 cycle.
- cpu_reset falls the same cycle boot rises. boot is high exactly BOOT_CYCLES cycles.
- Press latency: a press held stable is reported after at most (DEB_TICKS+1)·TICK_DIV+3 cycles. A state change follows 1 cycle after btn_press.
- Counters saturate or reload only. No wrap-around is observable. The prescaler wraps from TICK_DIV-1 to 0 and emits one tick.
- reset_n assertion mid-sequence forces S_INIT immediately (asynchronously).

## Configuration
- SUPPORT_CALIB_TIMEOUT_EN defined: S_CALIB counts cycles. After CALIB_TIMEOUT cycles without lpddr_calib_done, the block sets calib_err=1 and proceeds to S_CPURST. calib_err clears only on reset_n.
- Not defined: S_CALIB waits indefinitely, calib_err is tied 0, and the timeout counter is absent.

## Test plan
Parameters for all cases: TICK_DIV=4, DEB_TICKS=3, DCM_CYCLES=8, RST_CYCLES=4, BOOT_CYCLES=2, CALIB_TIMEOUT=100.
- Cold start: release reset_n with calib_done=1 → dcm_reset=1 on cycles 0–7, lpddr_reset=1 on 8–11, cpu_reset falls and boot=1 on cycles 17–18, S_RUN from 19.
- Bounce: button[0] toggling every 3 cycles for 40 cycles → no btn_press. Then a steady 1 → exactly one btn_press[0] pulse within 19 cycles, then lpddr_reset reasserted.
- Warm reset: in S_RUN, press button[1] → cpu_reset=1 for 4 cycles, boot for 2 cycles, lpddr_reset and dcm_reset stay 0.
- Halt/interrupt: press button[2] twice → halt 0→1→0. Press button[3] → interrupt=1 until int_ack pulse. A second press while pending is ignored. interrupt is cleared 1 cycle after int_ack.
- Timeout (macro defined): hold calib_done=0 → after 100 cycles in S_CALIB, calib_err=1 and sequence continues. Macro undefined: sequence stalls and calib_err stays 0.
- Simultaneous buttons: press button[0] and button[1] in the same tick → full reset path (lpddr_reset=1).

Source files
------------

// File: rtl/support_seq.sv
// Board reset/boot sequencer with button debounce; SUPPORT_CALIB_TIMEOUT_EN adds a calibration watchdog.
// Latency: all outputs registered; state change 1 cycle after btn_press; press reported <= (DEB_TICKS+1)*TICK_DIV+3 cycles.
// Backpressure: none; every input is sampled each cycle and no handshake can stall the sequencer.
module support_seq #(
    parameter int TICK_DIV      = 4096,
    parameter int DEB_TICKS     = 10,
    parameter int NUM_BTN       = 4,
    parameter int DCM_CYCLES    = 64,
    parameter int RST_CYCLES    = 16,
    parameter int BOOT_CYCLES   = 4,
    parameter int CALIB_TIMEOUT = 1048576
) (
    input  logic               sysclk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] button,
    input  logic               lpddr_calib_done,
    input  logic               int_ack,
    output logic               dcm_reset,
    output logic               lpddr_reset,
    output logic               cpu_reset,
    output logic               boot,
    output logic               halt,
    output logic               interrupt,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               calib_err
);

    localparam int PW        = $clog2(TICK_DIV);
    localparam int PM1       = (DCM_CYCLES > RST_CYCLES) ? DCM_CYCLES : RST_CYCLES;
    localparam int PHASE_MAX = (PM1 > BOOT_CYCLES) ? PM1 : BOOT_CYCLES;
    localparam int CW        = $clog2(PHASE_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT, S_MEMRST, S_CALIB, S_CPURST, S_BOOT, S_RUN
    } state_t;

    logic [PW-1:0]                       pre_cnt;
    logic                                tick;
    logic [NUM_BTN-1:0]                  sync_meta, sync_q;
    logic [NUM_BTN-1:0][DEB_TICKS-2:0]   hist, hist_nxt;
    logic [NUM_BTN-1:0]                  deb, deb_nxt;
    logic [DEB_TICKS-1:0]                shifted;

    state_t         state, state_nxt;
    logic [CW-1:0]  phase_cnt, phase_nxt;
    logic           calib_expire;
    logic           entering_rst;
    logic           dcm_nxt, lpddr_nxt, cpu_nxt, boot_nxt, halt_nxt, int_nxt;

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    // Histories hold the previous DEB_TICKS-1 tick samples; the live sample completes the window.
    always_comb begin
        hist_nxt = hist;
        deb_nxt  = deb;
        shifted  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (tick) begin
                shifted     = {hist[i], sync_q[i]};
                hist_nxt[i] = shifted[DEB_TICKS-2:0];
                if (&shifted)
                    deb_nxt[i] = 1'b1;
                else if (~|shifted)
                    deb_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt   <= '0;
            sync_meta <= '0;
            sync_q    <= '0;
            hist      <= '0;
            deb       <= '0;
            btn_press <= '0;
        end else begin
            pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
            sync_meta <= button;
            sync_q    <= sync_meta;
            hist      <= hist_nxt;
            deb       <= deb_nxt;
            btn_press <= deb_nxt & ~deb;
        end
    end

`ifdef SUPPORT_CALIB_TIMEOUT_EN
    localparam int CTW = $clog2(CALIB_TIMEOUT + 1);
    logic [CTW-1:0] calib_cnt;

    assign calib_expire = (state == S_CALIB) && !lpddr_calib_done &&
                          (calib_cnt == CTW'(CALIB_TIMEOUT - 1));

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            calib_cnt <= '0;
            calib_err <= 1'b0;
        end else begin
            calib_cnt <= (state == S_CALIB) ? calib_cnt + 1'b1 : '0;
            if (calib_expire)
                calib_err <= 1'b1;
        end
    end
`else
    localparam int unused_calib_timeout = CALIB_TIMEOUT;
    assign calib_expire = 1'b0;
    assign calib_err    = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_INIT;
            phase_cnt <= CW'(DCM_CYCLES - 1);
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   if (phase_cnt == '0) state_nxt = S_MEMRST;
            S_MEMRST: if (phase_cnt == '0) state_nxt = S_CALIB;
            S_CALIB:  if (lpddr_calib_done || calib_expire) state_nxt = S_CPURST;
            S_CPURST: if (phase_cnt == '0) state_nxt = S_BOOT;
            S_BOOT:   if (phase_cnt == '0) state_nxt = S_RUN;
            S_RUN:    state_nxt = S_RUN;
            default:  state_nxt = S_INIT;
        endcase
        // Full reset outranks warm reset when both presses land together.
        if (btn_press[0] && state != S_INIT && state != S_MEMRST)
            state_nxt = S_MEMRST;
        else if (btn_press[1] && state == S_RUN)
            state_nxt = S_CPURST;

        phase_nxt = phase_cnt;
        if (state_nxt != state) begin
            case (state_nxt)
                S_INIT:   phase_nxt = CW'(DCM_CYCLES - 1);
                S_MEMRST: phase_nxt = CW'(RST_CYCLES - 1);
                S_CPURST: phase_nxt = CW'(RST_CYCLES - 1);
                S_BOOT:   phase_nxt = CW'(BOOT_CYCLES - 1);
                default:  phase_nxt = '0;
            endcase
        end else if (phase_cnt != '0) begin
            phase_nxt = phase_cnt - 1'b1;
        end
    end

    // Outputs decode the upcoming state so the registered copies line up with the state register.
    always_comb begin
        entering_rst = (state_nxt != state) &&
                       (state_nxt == S_MEMRST || state_nxt == S_CPURST);
        dcm_nxt   = (state_nxt == S_INIT);
        lpddr_nxt = (state_nxt == S_MEMRST);
        cpu_nxt   = (state_nxt == S_INIT) || (state_nxt == S_MEMRST) ||
                    (state_nxt == S_CALIB) || (state_nxt == S_CPURST);
        boot_nxt  = (state_nxt == S_BOOT);

        halt_nxt = halt;
        if (entering_rst)
            halt_nxt = 1'b0;
        else if (btn_press[2] && state == S_RUN)
            halt_nxt = ~halt;

        int_nxt = interrupt;
        if (entering_rst || int_ack)
            int_nxt = 1'b0;
        else if (btn_press[3] && state == S_RUN)
            int_nxt = 1'b1;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            dcm_reset   <= 1'b1;
            lpddr_reset <= 1'b0;
            cpu_reset   <= 1'b1;
            boot        <= 1'b0;
            halt        <= 1'b0;
            interrupt   <= 1'b0;
        end else begin
            dcm_reset   <= dcm_nxt;
            lpddr_reset <= lpddr_nxt;
            cpu_reset   <= cpu_nxt;
            boot        <= boot_nxt;
            halt        <= halt_nxt;
            interrupt   <= int_nxt;
        end
    end

endmodule

// File: tb/tb_support_seq.sv
// Directed bench for support_seq with small timing parameters.
module tb_support_seq;

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] button = 4'b0;
    logic       lpddr_calib_done = 1'b1;
    logic       int_ack = 1'b0;
    logic       dcm_reset, lpddr_reset, cpu_reset, boot, halt, interrupt, calib_err;
    logic [3:0] btn_press;

    int n_chk  = 0;
    int n_fail = 0;

    support_seq #(
        .TICK_DIV(4), .DEB_TICKS(3), .NUM_BTN(4), .DCM_CYCLES(8),
        .RST_CYCLES(4), .BOOT_CYCLES(2), .CALIB_TIMEOUT(100)
    ) dut (
        .sysclk(sysclk), .reset_n(reset_n), .button(button),
        .lpddr_calib_done(lpddr_calib_done), .int_ack(int_ack),
        .dcm_reset(dcm_reset), .lpddr_reset(lpddr_reset), .cpu_reset(cpu_reset),
        .boot(boot), .halt(halt), .interrupt(interrupt),
        .btn_press(btn_press), .calib_err(calib_err)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic wait_run(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if ({dcm_reset, lpddr_reset, cpu_reset, boot} == 4'b0000) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        check(tag, ok, 1);
    endtask

    // Returns in the cycle where the debounced press is visible.
    task automatic press(input int idx, input string tag);
        bit seen = 1'b0;
        button[idx] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            cyc();
            if (btn_press[idx]) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1);
    endtask

    task automatic release_btn(input int idx);
        button[idx] = 1'b0;
        repeat (20) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        int presses;
        int first;
        bit prev;
        bit seen;

        repeat (3) cyc();
        check("rst_resets", {dcm_reset, lpddr_reset, cpu_reset, boot}, 4'b1010);
        check("rst_misc", {halt, interrupt, calib_err, btn_press}, 0);

        // Cold start with calibration already done
        @(negedge sysclk);
        reset_n = 1'b1;
        #1;
        for (int k = 0; k < 21; k++) begin
            e[3] = (k < 8);
            e[2] = (k >= 8 && k < 12);
            e[1] = (k < 17);
            e[0] = (k >= 17 && k < 19);
            check($sformatf("cold_c%0d", k), {dcm_reset, lpddr_reset, cpu_reset, boot}, e);
            cyc();
        end

        // Bouncing reset button must not produce a press
        presses = 0;
        for (int c = 0; c < 40; c++) begin
            button[0] = ((c / 3) % 2 == 0);
            cyc();
            if (btn_press != 4'b0) presses++;
        end
        check("bounce_quiet", presses, 0);

        button[0] = 1'b1;
        presses = 0;
        first = -1;
        prev = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            cyc();
            if (prev) check("bounce_lpddr", lpddr_reset, 1);
            prev = btn_press[0];
            if (btn_press[0]) begin
                presses++;
                if (first < 0) first = k;
            end
        end
        check("bounce_one_press", presses, 1);
        check("bounce_latency", (first >= 1 && first <= 19), 1);
        release_btn(0);
        wait_run("run_after_full");

        // Warm reset
        press(1, "warm_press");
        for (int j = 1; j <= 7; j++) begin
            cyc();
            e = (j <= 4) ? 4'b0010 : (j <= 6) ? 4'b0001 : 4'b0000;
            check($sformatf("warm_c%0d", j), {dcm_reset, lpddr_reset, cpu_reset, boot}, e);
        end
        release_btn(1);

        // Halt toggle
        check("halt_init", halt, 0);
        press(2, "halt_press1");
        cyc();
        check("halt_on", halt, 1);
        release_btn(2);
        press(2, "halt_press2");
        cyc();
        check("halt_off", halt, 0);
        release_btn(2);

        // Interrupt handshake
        check("int_init", interrupt, 0);
        press(3, "int_press1");
        cyc();
        check("int_set", interrupt, 1);
        release_btn(3);
        check("int_hold", interrupt, 1);
        press(3, "int_press2");
        cyc();
        check("int_drop_2nd", interrupt, 1);
        button[3] = 1'b0;
        int_ack = 1'b1;
        check("int_ack_same_cycle", interrupt, 1);
        cyc();
        int_ack = 1'b0;
        check("int_cleared", interrupt, 0);
        repeat (20) cyc();

        press(3, "int_press3");
        cyc();
        check("int_set_again", interrupt, 1);
        release_btn(3);
        press(3, "int_press4");
        int_ack = 1'b1;
        cyc();
        int_ack = 1'b0;
        check("int_ack_vs_press", interrupt, 0);
        release_btn(3);

        // Reset and boot pressed together
        button[1:0] = 2'b11;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            if (btn_press[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("simul_seen", seen, 1);
        check("simul_both", btn_press[1:0], 2'b11);
        cyc();
        check("simul_full", {lpddr_reset, cpu_reset}, 2'b11);
        button[1:0] = 2'b00;
        repeat (20) cyc();
        wait_run("run_after_simul");

        // Asynchronous reset mid-run clears halt
        press(2, "halt_press3");
        cyc();
        check("halt_before_rst", halt, 1);
        release_btn(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst", {dcm_reset, lpddr_reset, cpu_reset, boot, halt}, 5'b10100);

        // Calibration never completes
        lpddr_calib_done = 1'b0;
        cyc();
        reset_n = 1'b1;
        repeat (111) cyc();
`ifdef SUPPORT_CALIB_TIMEOUT_EN
        check("calib_err_pre", calib_err, 0);
        check("calib_wait", {lpddr_reset, cpu_reset, boot}, 3'b010);
        cyc();
        check("calib_err_set", calib_err, 1);
        repeat (4) cyc();
        check("timeout_boot", boot, 1);
        lpddr_calib_done = 1'b1;
        wait_run("run_after_timeout");
        check("calib_err_sticky", calib_err, 1);
`else
        repeat (100) cyc();
        check("stall_err", calib_err, 0);
        check("stall_state", {dcm_reset, lpddr_reset, cpu_reset, boot}, 4'b0010);
        lpddr_calib_done = 1'b1;
        wait_run("run_after_calib");
        check("stall_err_after", calib_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
